online_digit_feeder: RTL and testbench

//  Upstream stage of the CA register store. Accepts two operands (x, y) in borrow-save

---
 rtl/online_div_defs_pkg.sv | 27 ++
 rtl/online_digit_feeder_sd_shift_reg.sv | 36 +++
 rtl/online_digit_feeder.sv | 122 ++++++++++++
 tb/tb_online_digit_feeder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/online_div_defs_pkg.sv
// rtl/online_div_defs_pkg.sv - shared FSM states, signed-digit encodings and default widths
package online_div_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_CNT_W  = 9;

  // 2'b11 is a redundant zero; the register store only understands the three legal codes
  function automatic logic [1:0] sd_canon(input logic [1:0] d);
    case (d)
      SD_POS:  return SD_POS;
      SD_NEG:  return SD_NEG;
      default: return SD_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/online_digit_feeder_sd_shift_reg.sv
// rtl/online_digit_feeder_sd_shift_reg.sv - MSD-first borrow-save shift register with registered digit
module sd_shift_reg
  import online_div_defs::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift_en,
  input  logic [N-1:0] plus_in,
  input  logic [N-1:0] minus_in,
  output logic [1:0]   digit
);

  logic [N-1:0] plus_q;
  logic [N-1:0] minus_q;

  // Load presents the MSD immediately; zeros shift in so flush digits fall out as SD_ZERO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      plus_q  <= '0;
      minus_q <= '0;
      digit   <= SD_ZERO;
    end else if (load) begin
      digit   <= sd_canon({plus_in[N-1], minus_in[N-1]});
      plus_q  <= plus_in << 1;
      minus_q <= minus_in << 1;
    end else if (shift_en) begin
      digit   <= sd_canon({plus_q[N-1], minus_q[N-1]});
      plus_q  <= plus_q << 1;
      minus_q <= minus_q << 1;
    end
  end

endmodule

// File: rtl/online_digit_feeder.sv
// rtl/online_digit_feeder.sv - serialises two borrow-save operands MSD-first into the CA register store
module online_digit_feeder
  import online_div_defs::*;
#(
  parameter int NUM_DIGITS = 16,
  parameter int DELTA      = 3,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [NUM_DIGITS-1:0] op_x_plus,
  input  logic [NUM_DIGITS-1:0] op_x_minus,
  input  logic [NUM_DIGITS-1:0] op_y_plus,
  input  logic [NUM_DIGITS-1:0] op_y_minus,
  input  logic                  hold,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            x_input,
  output logic [1:0]            y_input,
  output logic                  we,
  output logic [CNT_W-1:0]      cnt,
  output logic [ADDR_W-1:0]     computation_cycles
);

  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(NUM_DIGITS + DELTA - 1);
  localparam logic [CNT_W-1:0] FIRST_FLUSH = CNT_W'(NUM_DIGITS);

  if (NUM_DIGITS + DELTA > (1 << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too narrow to count NUM_DIGITS+DELTA digits");
  end
  if (NUM_DIGITS % 4 != 0) begin : g_word_check
    $error("NUM_DIGITS must be a multiple of 4");
  end

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt_nx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_nx;
  logic              we_nx;
  logic              load;
  logic              shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      we                 <= 1'b0;
      computation_cycles <= '0;
      base_q             <= '0;
    end else begin
      state              <= state_nx;
      cnt                <= cnt_nx;
      we                 <= we_nx;
      computation_cycles <= addr_nx;
      if (load) base_q <= base_addr;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    we_nx    = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = STREAM;
          cnt_nx   = '0;
          we_nx    = 1'b1;
          load     = 1'b1;
        end
      end
      STREAM, FLUSH: begin
        // A held cycle issues nothing: every register keeps its value and we drops
        if (!hold) begin
          if (cnt == LAST_CNT) begin
            state_nx = DONE;
          end else begin
            cnt_nx = cnt + 1'b1;
            we_nx  = 1'b1;
            shift  = 1'b1;
            if (cnt_nx >= FIRST_FLUSH) state_nx = FLUSH;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    addr_nx = load ? base_addr : base_q + ADDR_W'(cnt_nx >> 2);
  end

  assign ready = (state == IDLE);
  assign busy  = (state == STREAM) || (state == FLUSH);
  assign done  = (state == DONE);

  sd_shift_reg #(.N(NUM_DIGITS)) u_x_sreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift_en (shift),
    .plus_in  (op_x_plus),
    .minus_in (op_x_minus),
    .digit    (x_input)
  );

  sd_shift_reg #(.N(NUM_DIGITS)) u_y_sreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift_en (shift),
    .plus_in  (op_y_plus),
    .minus_in (op_y_minus),
    .digit    (y_input)
  );

endmodule

// File: tb/tb_online_digit_feeder.sv
// tb/tb_online_digit_feeder.sv - self-checking bench for online_digit_feeder
module tb_online_digit_feeder;

  localparam int N  = 16;
  localparam int D  = 3;
  localparam int AW = 7;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          rst_n, start, hold;
  logic [AW-1:0] base_addr;
  logic [N-1:0]  xp, xm, yp, ym;
  logic          ready, busy, done, we;
  logic [1:0]    x_input, y_input;
  logic [CW-1:0] cnt;
  logic [AW-1:0] computation_cycles;

  always #5 clk = ~clk;

  online_digit_feeder #(.NUM_DIGITS(N), .DELTA(D), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .base_addr          (base_addr),
    .op_x_plus          (xp),
    .op_x_minus         (xm),
    .op_y_plus          (yp),
    .op_y_minus         (ym),
    .hold               (hold),
    .ready              (ready),
    .busy               (busy),
    .done               (done),
    .x_input            (x_input),
    .y_input            (y_input),
    .we                 (we),
    .cnt                (cnt),
    .computation_cycles (computation_cycles)
  );

  typedef struct {
    int x;
    int y;
    int cnt;
    int addr;
    bit last;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   log_x[$], log_y[$], log_cnt[$], log_addr[$], log_cyc[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   cyc = 0;
  bit   exp_done = 0;
  bit   nd;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Value of one signed digit from its plus/minus bits, in the legal encoding
  function automatic int sd_val(input logic p, input logic m);
    if (p && !m) return 2;
    if (!p && m) return 1;
    return 0;
  endfunction

  task automatic push_op(input int base, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] c, input logic [N-1:0] d);
    exp_t t;
    for (int k = 0; k < N + D; k++) begin
      t.x    = (k < N) ? sd_val(a[N-1-k], b[N-1-k]) : 0;
      t.y    = (k < N) ? sd_val(c[N-1-k], d[N-1-k]) : 0;
      t.cnt  = k;
      t.addr = (base + k / 4) % (1 << AW);
      t.last = (k == N + D - 1);
      q.push_back(t);
    end
  endtask

  task automatic clear_log();
    log_x.delete(); log_y.delete(); log_cnt.delete(); log_addr.delete(); log_cyc.delete();
    n_done = 0;
  endtask

  task automatic set_ops(input int base, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] c, input logic [N-1:0] d);
    base_addr = AW'(base);
    xp = a; xm = b; yp = c; ym = d;
  endtask

  task automatic run_op(input int base, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] c, input logic [N-1:0] d);
    @(posedge clk); #1;
    set_ops(base, a, b, c, d);
    push_op(base, a, b, c, d);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic wait_we_cnt(input int k);
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (we && cnt == CW'(k)) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("we_cnt_timeout", 0, 1);
  endtask

  // Scoreboard: every we cycle must match the next queued digit; done follows the last one
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (done) n_done++;
      check("done_timing", done, exp_done);
      nd = 0;
      if (we) begin
        check("busy_with_we", busy, 1);
        if (q.size() == 0) begin
          check("unexpected_we", 1, 0);
        end else begin
          e = q.pop_front();
          check("x_input", x_input, e.x);
          check("y_input", y_input, e.y);
          check("cnt", cnt, e.cnt);
          check("addr", computation_cycles, e.addr);
          log_x.push_back(x_input);
          log_y.push_back(y_input);
          log_cnt.push_back(cnt);
          log_addr.push_back(computation_cycles);
          log_cyc.push_back(cyc);
          nd = e.last;
        end
      end
      exp_done = nd;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;
    rst_n = 1'b0; start = 1'b0; hold = 1'b0;
    set_ops(0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", we, 0);
    check("rst_x", x_input, 0);
    check("rst_y", y_input, 0);
    check("rst_cnt", cnt, 0);
    check("rst_addr", computation_cycles, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic: +1 in the MSD of x
    clear_log();
    run_op(10, 16'h8000, 16'h0000, 16'h0000, 16'h0000);
    wait_done();
    @(negedge clk);
    check("basic_ready_after", ready, 1);
    check("basic_we_count", log_x.size(), 19);
    if (log_x.size() == 19) begin
      check("basic_consecutive", log_cyc[18] - log_cyc[0], 18);
      check("basic_x0", log_x[0], 2);
      check("basic_x1", log_x[1], 0);
      check("basic_addr0", log_addr[0], 10);
      check("basic_addr3", log_addr[3], 10);
      check("basic_addr4", log_addr[4], 11);
      check("basic_addr18", log_addr[18], 14);
      check("basic_cnt18", log_cnt[18], 18);
    end
    check("basic_done_once", n_done, 1);
    check("basic_drained", q.size(), 0);

    // Canonicalisation and negative digit
    clear_log();
    run_op(0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001);
    wait_done();
    @(negedge clk);
    nz = 0;
    foreach (log_x[i]) if (log_x[i] != 0) nz++;
    check("canon_x_nonzero", nz, 0);
    check("canon_we_count", log_y.size(), 19);
    if (log_y.size() == 19) begin
      check("canon_y14", log_y[14], 0);
      check("canon_y15", log_y[15], 1);
      check("canon_y16", log_y[16], 0);
    end
    check("canon_drained", q.size(), 0);

    // Hold for three cycles while digit 6 is presented
    clear_log();
    run_op(20, 16'hA5C3, 16'h0A14, 16'h1234, 16'h8001);
    wait_we_cnt(6);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      if (i == 2) #1 hold = 1'b0;
      @(negedge clk);
      check("hold_we", we, 0);
      check("hold_cnt", cnt, 6);
    end
    wait_done();
    @(negedge clk);
    check("hold_we_count", log_cnt.size(), 19);
    if (log_cnt.size() == 19) begin
      check("hold_span", log_cyc[18] - log_cyc[0], 21);
      check("hold_cnt7", log_cnt[7], 7);
    end
    check("hold_drained", q.size(), 0);

    // Address wrap, start held high through DONE for a back-to-back second operation
    clear_log();
    @(posedge clk); #1;
    set_ops(126, 16'h0F0F, 16'hF000, 16'h00FF, 16'h0100);
    push_op(126, 16'h0F0F, 16'hF000, 16'h00FF, 16'h0100);
    start = 1'b1;
    @(posedge clk); #1;
    set_ops(3, 16'h1111, 16'h2222, 16'h4001, 16'h0002);
    push_op(3, 16'h1111, 16'h2222, 16'h4001, 16'h0002);
    wait_done();
    check("b2b_ready_in_done", ready, 0);
    @(negedge clk);
    check("b2b_idle_ready", ready, 1);
    check("b2b_idle_we", we, 0);
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    @(negedge clk);
    check("b2b_we_count", log_addr.size(), 38);
    if (log_addr.size() == 38) begin
      check("wrap_addr0", log_addr[0], 126);
      check("wrap_addr4", log_addr[4], 127);
      check("wrap_addr8", log_addr[8], 0);
      check("wrap_addr12", log_addr[12], 1);
      check("wrap_addr16", log_addr[16], 2);
      check("b2b_addr19", log_addr[19], 3);
      check("b2b_gap", log_cyc[19] - log_cyc[18], 3);
    end
    check("b2b_done_count", n_done, 2);
    check("b2b_drained", q.size(), 0);

    // start with new operands during STREAM must be ignored
    clear_log();
    run_op(40, 16'hC3A5, 16'h0042, 16'h7E00, 16'h0081);
    wait_we_cnt(3);
    set_ops(99, 16'h5A5A, 16'hA5A5, 16'hFFFF, 16'h0000);
    start = 1'b1;
    check("ignore_ready", ready, 0);
    @(posedge clk); @(posedge clk); #1 start = 1'b0;
    wait_done();
    @(negedge clk);
    check("ignore_we_count", log_x.size(), 19);
    check("ignore_done_count", n_done, 1);
    check("ignore_drained", q.size(), 0);

    // Reset in the middle of STREAM
    clear_log();
    run_op(50, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF);
    wait_we_cnt(5);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_we", we, 0);
    check("abort_cnt", cnt, 0);
    check("abort_done", done, 0);
    check("abort_addr", computation_cycles, 0);
    check("abort_x", x_input, 0);
    q.delete();
    exp_done = 0;
    n_done = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("abort_no_done", n_done, 0);

    // Recovery after abort
    clear_log();
    run_op(5, 16'h0001, 16'h0000, 16'h8000, 16'h4000);
    wait_done();
    @(negedge clk);
    check("recover_we_count", log_x.size(), 19);
    check("recover_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
